// File: rtl/fifo_64_unpacker.sv
// Serializes IN_W-bit FIFO words into OUT_W-bit valid/ready beats, least-significant slice first.
// Holds the word being sent plus one prefetched word so consecutive words go out without a bubble.
module fifo_64_unpacker #(
    parameter int unsigned IN_W  = 64,
    parameter int unsigned OUT_W = 8,
    parameter int unsigned IDX_W = 3
) (
    input  logic             clk,
    input  logic             reset,
    output logic             fifo_re,
    input  logic [IN_W-1:0]  fifo_dout,
    input  logic             fifo_empty,
    output logic [OUT_W-1:0] out_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             out_last,
    output logic             busy
);

    localparam int unsigned RATIO = IN_W / OUT_W;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(RATIO - 1);

    logic [IN_W-1:0]  hold_reg_q, hold_reg_d;
    logic [IN_W-1:0]  next_reg_q, next_reg_d;
    logic             hold_v_q, hold_v_d;
    logic             next_v_q, next_v_d;
    logic             pend_q;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [1:0]       slots_used;
    logic             xfer, retire, hold_free;

    // Occupancy counts in-flight reads so at most two words are ever owned.
    always_comb begin
        slots_used = 2'(hold_v_q) + 2'(next_v_q) + 2'(pend_q);
        fifo_re    = !reset && !fifo_empty && (slots_used < 2'd2);
    end

    assign out_valid = hold_v_q;
    assign out_last  = hold_v_q && (idx_q == LAST_IDX);
    assign out_data  = hold_reg_q[32'(idx_q) * OUT_W +: OUT_W];
    assign busy      = hold_v_q | next_v_q | pend_q;

    assign xfer      = hold_v_q && out_ready;
    assign retire    = xfer && (idx_q == LAST_IDX);
    assign hold_free = !hold_v_q || retire;

    always_comb begin
        hold_reg_d = hold_reg_q;
        hold_v_d   = hold_v_q;
        next_reg_d = next_reg_q;
        next_v_d   = next_v_q;
        idx_d      = idx_q;

        if (xfer) begin
            idx_d = retire ? '0 : idx_q + IDX_W'(1);
        end

        if (hold_free) begin
            if (next_v_q) begin
                // Promote the prefetch; any word arriving now becomes the new prefetch.
                hold_reg_d = next_reg_q;
                hold_v_d   = 1'b1;
                idx_d      = '0;
                next_v_d   = pend_q;
                if (pend_q) begin
                    next_reg_d = fifo_dout;
                end
            end else begin
                hold_v_d = pend_q;
                if (pend_q) begin
                    hold_reg_d = fifo_dout;
                    idx_d      = '0;
                end
            end
        end else if (pend_q) begin
            next_reg_d = fifo_dout;
            next_v_d   = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            hold_reg_q <= '0;
            next_reg_q <= '0;
            hold_v_q   <= 1'b0;
            next_v_q   <= 1'b0;
            pend_q     <= 1'b0;
            idx_q      <= '0;
        end else begin
            hold_reg_q <= hold_reg_d;
            next_reg_q <= next_reg_d;
            hold_v_q   <= hold_v_d;
            next_v_q   <= next_v_d;
            pend_q     <= fifo_re;
            idx_q      <= idx_d;
        end
    end

endmodule
